hbmc_hs_queue: RTL and testbench

Single-clock, parametrised handshake queue that accepts words over a level (four-phase) req/ack source port and delivers them over a destination port in four-phase or two-phase (toggle) mode. It buffers up to C_DEPTH words, so a slow consumer does not stall the producer on every transfer. It sits in the memory-clock domain directly behind the CDC bit synchronisers, between the configuration/command path and the HyperBus core FSM. All inputs are synchronous to `clk`; any CDC is done upstream.

---
 rtl/hbmc_hs_pkg.sv | 22 ++
 rtl/hbmc_hs_fifo_mem.sv | 69 ++++++
 rtl/hbmc_hs_queue.sv | 107 ++++++++++
 tb/tb_hbmc_hs_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hbmc_hs_pkg.sv
// Shared mode constants, FSM state encodings and sizing helper
// for the HyperBus handshake queue.
package hbmc_hs_pkg;

    localparam int HS_MODE_4PH = 0;
    localparam int HS_MODE_2PH = 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } hs_src_state_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_SET  = 1'b1
    } hs_dst_state_e;

    function automatic int hs_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/hbmc_hs_fifo_mem.sv
// Storage array with wrapping read/write pointers and an occupancy count.
// Callers guarantee no push when full and no pop when empty.
module hbmc_hs_fifo_mem
    import hbmc_hs_pkg::*;
#(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [C_DATA_WIDTH-1:0]        wdata_i,
    input  logic                           pop_i,
    output logic [C_DATA_WIDTH-1:0]        rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [hs_ptr_width(C_DEPTH):0] fill_level_o
);

    localparam int          PW      = hs_ptr_width(C_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [PW:0] DEPTH_L = CW'(C_DEPTH);

    logic [C_DATA_WIDTH-1:0] mem_q [C_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW:0]             count_q,  count_d;

    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o      = mem_q[rd_ptr_q];
    assign full_o       = (count_q == DEPTH_L);
    assign empty_o      = (count_q == '0);
    assign fill_level_o = count_q;

    no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
    no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/hbmc_hs_queue.sv
// Handshake queue: four-phase source port, four-phase or toggle destination port,
// with C_DEPTH words of buffering between them.
module hbmc_hs_queue
    import hbmc_hs_pkg::*;
#(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_DEPTH      = 4,
    parameter int C_DST_MODE   = HS_MODE_4PH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [C_DATA_WIDTH-1:0]        src_data,
    input  logic                           src_req,
    output logic                           src_ack,
    output logic [C_DATA_WIDTH-1:0]        dst_data,
    output logic                           dst_req,
    input  logic                           dst_ack,
    output logic [hs_ptr_width(C_DEPTH):0] fill_level
);

    logic                    push, pop, full, empty;
    logic [C_DATA_WIDTH-1:0] head_data;
    logic [C_DATA_WIDTH-1:0] dst_data_q;
    hs_src_state_e           src_state_q, src_state_d;

    hbmc_hs_fifo_mem #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_DEPTH      (C_DEPTH)
    ) u_mem (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .wdata_i      (src_data),
        .pop_i        (pop),
        .rdata_o      (head_data),
        .full_o       (full),
        .empty_o      (empty),
        .fill_level_o (fill_level)
    );

    always_comb begin
        src_state_d = src_state_q;
        push        = 1'b0;
        case (src_state_q)
            S_IDLE: if (src_req && !full) begin
                push        = 1'b1;
                src_state_d = S_WAIT;
            end
            S_WAIT: if (!src_req) src_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) src_state_q <= S_IDLE;
        else     src_state_q <= src_state_d;
    end

    // The acknowledge is the S_WAIT state flop itself, so it is glitch-free.
    assign src_ack = (src_state_q == S_WAIT);

    generate
        if (C_DST_MODE == HS_MODE_2PH) begin : g_dst_2ph
            logic dst_req_q, dst_req_d;

            always_comb begin
                pop       = !empty && (dst_ack == dst_req_q);
                dst_req_d = pop ? ~dst_req_q : dst_req_q;
            end

            always_ff @(posedge clk) begin
                if (rst) dst_req_q <= 1'b0;
                else     dst_req_q <= dst_req_d;
            end

            assign dst_req = dst_req_q;
        end else begin : g_dst_4ph
            hs_dst_state_e dst_state_q, dst_state_d;

            always_comb begin
                dst_state_d = dst_state_q;
                pop         = 1'b0;
                case (dst_state_q)
                    D_IDLE: if (!empty && !dst_ack) begin
                        pop         = 1'b1;
                        dst_state_d = D_SET;
                    end
                    D_SET: if (dst_ack) dst_state_d = D_IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) dst_state_q <= D_IDLE;
                else     dst_state_q <= dst_state_d;
            end

            assign dst_req = (dst_state_q == D_SET);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)      dst_data_q <= '0;
        else if (pop) dst_data_q <= head_data;
    end

    assign dst_data = dst_data_q;

endmodule

// File: tb/tb_hbmc_hs_queue.sv
// Bench for hbmc_hs_queue: one four-phase and one toggle-mode instance,
// checked every cycle against a queue-level model plus directed expectations.
module tb_hbmc_hs_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] src_req = 2'b00;
    logic [7:0] src_data [2];
    logic [1:0] src_ack;
    logic [1:0] dst_req;
    logic [7:0] dst_data [2];
    logic [2:0] fill [2];
    logic       dst_ack0 = 1'b0;
    logic       dst_ack1 = 1'b0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit cons_en0 = 1'b0;
    bit cons_en1 = 1'b0;
    int delay0 = 0;
    int tgl_cnt = 0;
    logic tgl_prev = 1'b0;
    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];

    always #5 clk = ~clk;

    hbmc_hs_queue #(.C_DATA_WIDTH(8), .C_DEPTH(DEPTH), .C_DST_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .src_data(src_data[0]), .src_req(src_req[0]), .src_ack(src_ack[0]),
        .dst_data(dst_data[0]), .dst_req(dst_req[0]), .dst_ack(dst_ack0), .fill_level(fill[0])
    );

    hbmc_hs_queue #(.C_DATA_WIDTH(8), .C_DEPTH(DEPTH), .C_DST_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .src_data(src_data[1]), .src_req(src_req[1]), .src_ack(src_ack[1]),
        .dst_data(dst_data[1]), .dst_req(dst_req[1]), .dst_ack(dst_ack1), .fill_level(fill[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue-level model: a list of stored words (head at index 0) plus the
    // word on the destination port and the two handshake levels.
    logic [1:0] m_src_ack = 2'b00;
    logic [1:0] m_dst_req = 2'b00;
    logic [7:0] m_dst_data [2];
    logic [7:0] mbuf [2][8];
    int         mcnt [2];

    always @(posedge clk) begin
        bit   do_push, do_pop;
        logic ack;
        for (int i = 0; i < 2; i++) begin
            ack = (i == 0) ? dst_ack0 : dst_ack1;
            if (rst) begin
                mcnt[i]       = 0;
                m_src_ack[i]  = 1'b0;
                m_dst_req[i]  = 1'b0;
                m_dst_data[i] = 8'h00;
            end else begin
                do_push = !m_src_ack[i] && src_req[i] && (mcnt[i] < DEPTH);
                if (i == 0) do_pop = (mcnt[i] > 0) && !m_dst_req[i] && !ack;
                else        do_pop = (mcnt[i] > 0) && (ack == m_dst_req[i]);
                if (m_src_ack[i] && !src_req[i]) m_src_ack[i] = 1'b0;
                if (i == 0 && m_dst_req[i] && ack) m_dst_req[i] = 1'b0;
                if (do_pop) begin
                    m_dst_data[i] = mbuf[i][0];
                    for (int k = 0; k < 7; k++) mbuf[i][k] = mbuf[i][k+1];
                    mcnt[i]--;
                    m_dst_req[i] = (i == 0) ? 1'b1 : ~m_dst_req[i];
                end
                if (do_push) begin
                    mbuf[i][mcnt[i]] = src_data[i];
                    mcnt[i]++;
                    m_src_ack[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("m%0d src_ack", i), 32'(src_ack[i]), 32'(m_src_ack[i]));
                check($sformatf("m%0d dst_req", i), 32'(dst_req[i]), 32'(m_dst_req[i]));
                check($sformatf("m%0d dst_data", i), 32'(dst_data[i]), 32'(m_dst_data[i]));
                check($sformatf("m%0d fill_level", i), 32'(fill[i]), 32'(mcnt[i]));
                check($sformatf("m%0d fill_range", i), 32'(fill[i] <= 3'd4), 32'd1);
            end
        end
    end

    // Four-phase consumer with a random acknowledge delay.
    always @(negedge clk) begin
        if (dst_ack0 && !dst_req[0]) begin
            dst_ack0 = 1'b0;
        end else if (cons_en0 && !dst_ack0 && dst_req[0]) begin
            if (delay0 == 0) begin
                rx0.push_back(dst_data[0]);
                dst_ack0 = 1'b1;
                delay0 = $urandom_range(0, 3);
            end else begin
                delay0--;
            end
        end
    end

    // Toggle consumer: echoes dst_req back on dst_ack half a cycle later.
    always @(negedge clk) begin
        if (dst_req[1] != tgl_prev) tgl_cnt++;
        tgl_prev = dst_req[1];
        if (cons_en1 && (dst_ack1 != dst_req[1])) begin
            rx1.push_back(dst_data[1]);
            dst_ack1 = dst_req[1];
        end
    end

    task automatic push_word(input int i, input logic [7:0] d);
        int n;
        src_data[i] = d;
        src_req[i]  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!src_ack[i] && n < 300);
        if (n >= 300) check($sformatf("push%0d ack_rise", i), 32'(src_ack[i]), 32'd1);
        src_req[i] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (src_ack[i] && n < 300);
        if (n >= 300) check($sformatf("push%0d ack_fall", i), 32'(src_ack[i]), 32'd0);
    endtask

    task automatic wait_rx(input int which, input int n);
        int t = 0;
        while (((which == 0) ? rx0.size() : rx1.size()) < n && t < 600) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("rx%0d count", which), (which == 0) ? rx0.size() : rx1.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        src_data[0] = 8'h00;
        src_data[1] = 8'h00;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Reset values
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d src_ack", i), 32'(src_ack[i]), 32'd0);
            check($sformatf("rst%0d dst_req", i), 32'(dst_req[i]), 32'd0);
            check($sformatf("rst%0d dst_data", i), 32'(dst_data[i]), 32'd0);
            check($sformatf("rst%0d fill", i), 32'(fill[i]), 32'd0);
        end

        // First-word latency, mode 0
        src_data[0] = 8'hA5;
        src_req[0]  = 1'b1;
        @(negedge clk);
        check("lat src_ack", 32'(src_ack[0]), 32'd1);
        check("lat fill1", 32'(fill[0]), 32'd1);
        check("lat dst_req0", 32'(dst_req[0]), 32'd0);
        @(negedge clk);
        check("lat dst_req1", 32'(dst_req[0]), 32'd1);
        check("lat dst_data", 32'(dst_data[0]), 32'hA5);
        check("lat fill0", 32'(fill[0]), 32'd0);
        src_req[0] = 1'b0;
        cons_en0 = 1'b1;
        wait_rx(0, 1);
        check("lat rx", 32'(rx0[0]), 32'hA5);
        cons_en0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0.delete();

        // Fill and backpressure
        for (int k = 1; k <= 5; k++) push_word(0, 8'(k));
        check("full fill", 32'(fill[0]), 32'd4);
        check("full dst_data", 32'(dst_data[0]), 32'h01);
        check("full dst_req", 32'(dst_req[0]), 32'd1);
        fork
            push_word(0, 8'h06);
            begin
                repeat (5) @(negedge clk);
                check("full blocked ack", 32'(src_ack[0]), 32'd0);
                check("full blocked fill", 32'(fill[0]), 32'd4);
                cons_en0 = 1'b1;
            end
        join
        wait_rx(0, 6);
        for (int k = 0; k < 6; k++) check($sformatf("full order %0d", k), 32'(rx0[k]), 32'(k + 1));
        repeat (4) @(negedge clk);
        rx0.delete();

        // Streaming with random consumer delay and producer gaps
        for (int k = 0; k < 20; k++) begin
            push_word(0, 8'(k));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_rx(0, 20);
        for (int k = 0; k < 20; k++) check($sformatf("stream order %0d", k), 32'(rx0[k]), 32'(k));
        cons_en0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0.delete();

        // Toggle-mode destination
        tgl_cnt  = 0;
        cons_en1 = 1'b1;
        for (int k = 0; k < 8; k++) push_word(1, 8'h30 + 8'(k));
        wait_rx(1, 8);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) check($sformatf("tgl order %0d", k), 32'(rx1[k]), 32'h30 + 32'(k));
        check("tgl count", tgl_cnt, 8);
        cons_en1 = 1'b0;

        // Reset with words queued and a request outstanding
        for (int k = 0; k < 4; k++) push_word(0, 8'hC0 + 8'(k));
        check("mid fill", 32'(fill[0]), 32'd3);
        check("mid dst_req", 32'(dst_req[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid src_ack", 32'(src_ack[0]), 32'd0);
        check("mid dst_req0", 32'(dst_req[0]), 32'd0);
        check("mid dst_data", 32'(dst_data[0]), 32'd0);
        check("mid fill0", 32'(fill[0]), 32'd0);
        cons_en0 = 1'b1;
        push_word(0, 8'h5A);
        wait_rx(0, 1);
        check("mid rx", 32'(rx0[0]), 32'h5A);
        repeat (4) @(negedge clk);
        check("mid fill_end", 32'(fill[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
